// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension unit: mode encodings and widths.
package imm_ext_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_SIGN   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_ZERO   = 2'd1;
  localparam logic [MODE_W-1:0] MODE_UPPER  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_BRANCH = 2'd3;

endpackage : imm_ext_pkg

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign, zero, upper (LUI) and branch-offset forms.
// Kept free of state so decode-stage users can reuse it directly.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic [IN_W-1:0]   imm,
  input  logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  ext
);

  localparam int PAD = OUT_W - IN_W;

  // Reject configurations where the shifted branch offset would lose bits.
  if (IN_W < 1) begin : g_bad_in_w
    $error("imm_ext_core: IN_W must be at least 1");
  end
  if (BR_SHIFT < 0 || BR_SHIFT > 4) begin : g_bad_shift
    $error("imm_ext_core: BR_SHIFT must be in 0..4");
  end
  if (OUT_W < IN_W + BR_SHIFT) begin : g_bad_out_w
    $error("imm_ext_core: OUT_W must be >= IN_W + BR_SHIFT");
  end

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] upper_ext;
  logic [OUT_W-1:0] branch_ext;

  // Sign extension comes from casting the signed immediate up to the output width.
  assign sign_ext   = OUT_W'($signed(imm));
  assign zero_ext   = OUT_W'(imm);
  assign upper_ext  = zero_ext << PAD;
  assign branch_ext = sign_ext << BR_SHIFT;

  // Select the extension form requested by the mode field.
  always_comb begin
    ext = sign_ext;
    case (mode)
      MODE_SIGN:   ext = sign_ext;
      MODE_ZERO:   ext = zero_ext;
      MODE_UPPER:  ext = upper_ext;
      MODE_BRANCH: ext = branch_ext;
      default:     ext = sign_ext;
    endcase
  end

endmodule : imm_ext_core

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with a valid/ready handshake, a one-entry skid
// register behind the output register, and a saturating transfer counter.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [MODE_W-1:0] out_mode,
  output logic [CNT_W-1:0]  xfer_cnt
);

  logic [OUT_W-1:0]  in_ext;
  logic              skid_valid;
  logic [OUT_W-1:0]  skid_data;
  logic [MODE_W-1:0] skid_mode;
  logic              accept;
  logic              out_fire;
  logic              out_load;

  imm_ext_core #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .BR_SHIFT (BR_SHIFT)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .ext  (in_ext)
  );

  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_load = ~out_valid | out_ready;

  // Output register and skid: skid has priority so order is preserved; in_ready
  // is registered from the next skid state so it never depends on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_mode   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_mode  <= '0;
      in_ready   <= 1'b1;
    end else if (out_load) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_mode   <= skid_mode;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_ext;
        out_mode  <= in_mode;
        in_ready  <= 1'b1;
      end else begin
        out_valid <= 1'b0;
        in_ready  <= 1'b1;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_ext;
      skid_mode  <= in_mode;
      in_ready   <= 1'b0;
    end
  end

  // Count output transfers, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_fire && (xfer_cnt != {CNT_W{1'b1}})) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule : imm_ext_pipe

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: default, narrow-width and small-counter builds.
module tb_imm_ext_pipe;

  logic clk;
  logic rst_n;

  // Default-parameter instance signals
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;
  logic [15:0] xfer_cnt;

  // Narrow instance signals (IN_W=8, OUT_W=16, BR_SHIFT=1)
  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_in_imm;
  logic [1:0]  s_in_mode;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [15:0] s_out_data;
  logic [1:0]  s_out_mode;
  logic [15:0] s_xfer_cnt;

  // Small-counter instance signals (CNT_W=3)
  logic        c_in_valid;
  logic        c_in_ready;
  logic [15:0] c_in_imm;
  logic [1:0]  c_in_mode;
  logic        c_out_valid;
  logic        c_out_ready;
  logic [31:0] c_out_data;
  logic [1:0]  c_out_mode;
  logic [2:0]  c_xfer_cnt;

  int check_count;
  int error_count;

  imm_ext_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .xfer_cnt  (xfer_cnt)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(16), .BR_SHIFT(1), .CNT_W(16)) dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_imm    (s_in_imm),
    .in_mode   (s_in_mode),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .out_mode  (s_out_mode),
    .xfer_cnt  (s_xfer_cnt)
  );

  imm_ext_pipe #(.CNT_W(3)) dut_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (c_in_valid),
    .in_ready  (c_in_ready),
    .in_imm    (c_in_imm),
    .in_mode   (c_in_mode),
    .out_valid (c_out_valid),
    .out_ready (c_out_ready),
    .out_data  (c_out_data),
    .out_mode  (c_out_mode),
    .xfer_cnt  (c_xfer_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, actual, expected);
    end
  endtask

  // Drive the default instance's input side (called at a falling edge).
  task automatic applyStimulus(input logic valid, input logic [15:0] imm, input logic [1:0] mode);
    in_valid = valid;
    in_imm   = imm;
    in_mode  = mode;
  endtask

  // Present one input and check the result one cycle later on the default instance.
  task automatic sendCheck(input string tag, input logic [15:0] imm, input logic [1:0] mode,
                           input logic [31:0] exp);
    applyStimulus(1'b1, imm, mode);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, "_data"}, 64'(out_data), 64'(exp));
    checkOutput({tag, "_mode"}, 64'(out_mode), 64'(mode));
  endtask

  // Present one input and check the result one cycle later on the narrow instance.
  task automatic sendCheckSmall(input string tag, input logic [7:0] imm, input logic [1:0] mode,
                                input logic [15:0] exp);
    s_in_valid = 1'b1;
    s_in_imm   = imm;
    s_in_mode  = mode;
    @(negedge clk);
    checkOutput({tag, "_valid"}, 64'(s_out_valid), 64'd1);
    checkOutput({tag, "_data"}, 64'(s_out_data), 64'(exp));
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    rst_n       = 1'b0;
    applyStimulus(1'b0, 16'h0, 2'd0);
    out_ready   = 1'b1;
    s_in_valid  = 1'b0;
    s_in_imm    = 8'h0;
    s_in_mode   = 2'd0;
    s_out_ready = 1'b1;
    c_in_valid  = 1'b0;
    c_in_imm    = 16'h0;
    c_in_mode   = 2'd0;
    c_out_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_out_mode", 64'(out_mode), 64'd0);
    checkOutput("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back SIGN then ZERO with the output always drained
    sendCheck("sign_8000", 16'h8000, 2'd0, 32'hFFFF8000);
    sendCheck("zero_8000", 16'h8000, 2'd1, 32'h00008000);
    applyStimulus(1'b0, 16'h0, 2'd0);
    @(negedge clk);
    checkOutput("t1_idle_valid", 64'(out_valid), 64'd0);
    checkOutput("t1_xfer_cnt", 64'(xfer_cnt), 64'd2);

    // UPPER and BRANCH forms
    sendCheck("upper_1234", 16'h1234, 2'd2, 32'h12340000);
    sendCheck("branch_ffff", 16'hFFFF, 2'd3, 32'hFFFFFFFC);
    sendCheck("branch_0001", 16'h0001, 2'd3, 32'h00000004);
    applyStimulus(1'b0, 16'h0, 2'd0);
    @(negedge clk);
    checkOutput("t2_xfer_cnt", 64'(xfer_cnt), 64'd5);

    // Backpressure: first input fills output, second fills skid, third is refused
    out_ready = 1'b0;
    applyStimulus(1'b1, 16'h0001, 2'd0);
    @(negedge clk);
    checkOutput("bp_a_ready", 64'(in_ready), 64'd1);
    checkOutput("bp_a_data", 64'(out_data), 64'd1);
    applyStimulus(1'b1, 16'h0002, 2'd0);
    @(negedge clk);
    checkOutput("bp_b_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_b_data", 64'(out_data), 64'd1);
    applyStimulus(1'b1, 16'h0003, 2'd0);
    @(negedge clk);
    checkOutput("bp_c_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_c_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_c_data", 64'(out_data), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_d_data", 64'(out_data), 64'd2);
    checkOutput("bp_d_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    checkOutput("bp_e_data", 64'(out_data), 64'd3);
    checkOutput("bp_e_valid", 64'(out_valid), 64'd1);
    applyStimulus(1'b0, 16'h0, 2'd0);
    @(negedge clk);
    checkOutput("bp_f_valid", 64'(out_valid), 64'd0);
    checkOutput("bp_xfer_cnt", 64'(xfer_cnt), 64'd8);

    // Narrow build with imm 0x80 in every mode
    sendCheckSmall("n_sign", 8'h80, 2'd0, 16'hFF80);
    sendCheckSmall("n_zero", 8'h80, 2'd1, 16'h0080);
    sendCheckSmall("n_upper", 8'h80, 2'd2, 16'h8000);
    sendCheckSmall("n_branch", 8'h80, 2'd3, 16'hFF00);
    s_in_valid = 1'b0;
    @(negedge clk);

    // Ten transfers through a 3-bit counter must saturate at 7
    c_in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      c_in_imm = 16'(i);
      @(negedge clk);
      if (i == 4) checkOutput("cnt_after3", 64'(c_xfer_cnt), 64'd3);
      if (i == 8) checkOutput("cnt_after7", 64'(c_xfer_cnt), 64'd7);
    end
    c_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("cnt_sat", 64'(c_xfer_cnt), 64'd7);
    checkOutput("cnt_idle_valid", 64'(c_out_valid), 64'd0);

    // Asynchronous reset while output and skid are both full
    out_ready = 1'b0;
    applyStimulus(1'b1, 16'h0011, 2'd0);
    @(negedge clk);
    applyStimulus(1'b1, 16'h0022, 2'd0);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 2'd0);
    checkOutput("pre_rst_ready", 64'(in_ready), 64'd0);
    checkOutput("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_ready", 64'(in_ready), 64'd1);
    checkOutput("arst_cnt", 64'(xfer_cnt), 64'd0);
    checkOutput("arst_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("post_rst_cnt", 64'(xfer_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule : tb_imm_ext_pipe
